// File: rtl/core_pkg.sv
// Shared decode constants for the MIPS-subset core: opcodes, functs, ALU ops, ID/EX control layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation handed to EX; ALU_NOP keeps an all-zero control word a true nop
  typedef enum logic [3:0] {
    ALU_NOP = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  // idex_ctrl bit positions
  localparam int CTRL_W         = 10;
  localparam int CTRL_REG_WRITE = 9;
  localparam int CTRL_MEM_READ  = 8;
  localparam int CTRL_MEM_WRITE = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC   = 5;
  localparam int CTRL_JAL       = 4;
  localparam int CTRL_ALUOP_LSB = 0;

  // Field order mirrors the bit positions above
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    jal;
    alu_op_e alu_op;
  } ctrl_t;

  // Unsupported functs map to ALU_NOP so the caller can decode them as a nop
  function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      FN_SRL:  return ALU_SRL;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/decode_hazard_unit.sv
// Load-use and branch-operand hazard detection for the decode stage; produces the ID stall.
// Latency: combinational.
// Backpressure: ex_stall propagates straight into id_stall.
// Ports: if_valid + rs/rt + source-use flags from decode, EX/MEM destination/control, ex_stall in;
//        hazard (bubble request) and id_stall out.
module decode_hazard_unit #(
  parameter int AW     = 5,
  parameter int BR_FWD = 1
) (
  input  logic          if_valid,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          rt_src,
  input  logic          br_rs,
  input  logic          br_rt,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_dest,
  input  logic          mem_reg_write,
  input  logic          mem_mem_read,
  input  logic [AW-1:0] mem_dest,
  input  logic          ex_stall,
  output logic          hazard,
  output logic          id_stall
);

  logic load_use;
  logic ex_br;
  logic mem_busy;
  logic mem_br;

  assign load_use = ex_mem_read && (ex_dest != '0) &&
                    ((ex_dest == rs) || (rt_src && (ex_dest == rt)));

  // Branch/jr compare happens in ID, so any EX producer is too late to forward
  assign ex_br = ex_reg_write && (ex_dest != '0) &&
                 ((br_rs && (ex_dest == rs)) || (br_rt && (ex_dest == rt)));

  // Load data is not ready in MEM; ALU results are only forwardable when BR_FWD is set
  assign mem_busy = mem_mem_read || ((BR_FWD == 0) && mem_reg_write);
  assign mem_br   = mem_busy && (mem_dest != '0) &&
                    ((br_rs && (mem_dest == rs)) || (br_rt && (mem_dest == rt)));

  assign hazard   = if_valid && (load_use || ex_br || mem_br);
  assign id_stall = hazard || ex_stall;

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: control decode, WB-bypassed register file, branch/jump resolution, ID/EX register.
// Latency: 1 cycle IF/ID -> ID/EX; stall/redirect are combinational.
// Backpressure: ex_stall holds ID/EX and raises id_stall; hazards insert a bubble and stall IF/ID.
// Ports: clk/rst; IF/ID slot (if_*); EX/MEM hazard/forward inputs; WB write port;
//        id_stall/id_redirect(_pc) to fetch; idex_* register outputs to EX.
module decode_stage_pipe
  import core_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  PC_W   = 10,
  parameter int  NREGS  = 32,
  parameter int  BR_FWD = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc_plus1,
  input  logic              ex_stall,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [AW-1:0]     ex_dest,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [AW-1:0]     mem_dest,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              id_redirect,
  output logic [PC_W-1:0]   id_redirect_pc,
  output logic              idex_valid,
  output logic [CTRL_W-1:0] idex_ctrl,
  output logic [AW-1:0]     idex_rs,
  output logic [AW-1:0]     idex_rt,
  output logic [AW-1:0]     idex_dest,
  output logic [DATA_W-1:0] idex_rdata1,
  output logic [DATA_W-1:0] idex_rdata2,
  output logic [DATA_W-1:0] idex_imm,
  output logic [4:0]        idex_shamt,
  output logic [PC_W-1:0]   idex_link
);

  // Instruction fields
  logic [5:0]    opcode, funct;
  logic [AW-1:0] rs, rt, rd;
  logic [4:0]    shamt;
  logic [15:0]   imm16;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[21 +: AW];
  assign rt     = if_instr[16 +: AW];
  assign rd     = if_instr[11 +: AW];
  assign shamt  = if_instr[10:6];
  assign funct  = if_instr[5:0];
  assign imm16  = if_instr[15:0];

  // Control decode
  ctrl_t ctrl;
  logic  reg_dst, rt_src, zext;
  logic  is_beq, is_bne, is_j, is_jal, is_jr;

  always_comb begin
    ctrl    = '0;
    reg_dst = 1'b0;
    rt_src  = 1'b0;
    zext    = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    is_jal  = 1'b0;
    is_jr   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_dst = 1'b1;
        if (funct == FN_JR) begin
          is_jr = 1'b1;
        end else begin
          rt_src       = 1'b1;
          ctrl.alu_op  = funct_to_alu(funct);
          ctrl.reg_write = (funct_to_alu(funct) != ALU_NOP);
        end
      end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin
        is_jal         = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
      end
      OP_BEQ: begin is_beq = 1'b1; rt_src = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; rt_src = 1'b1; end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        zext           = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_AND;
      end
      OP_ORI: begin
        zext           = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        rt_src         = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] imm_ext;
  logic [AW-1:0]     dest;

  assign imm_ext = zext ? {{(DATA_W-16){1'b0}}, imm16} : {{(DATA_W-16){imm16[15]}}, imm16};
  assign dest    = is_jal ? AW'(31) : (reg_dst ? rd : rt);

  // Register file; r0 is never written and always reads zero
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && (wb_dest != '0)) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // Write-through: a same-cycle WB write is visible to the read
  logic [DATA_W-1:0] rd1, rd2;
  assign rd1 = (rs == '0) ? '0 : ((wb_we && (wb_dest == rs)) ? wb_data : regs[rs]);
  assign rd2 = (rt == '0) ? '0 : ((wb_we && (wb_dest == rt)) ? wb_data : regs[rt]);

  // Branch/jr operands additionally see the MEM-stage ALU result
  logic [DATA_W-1:0] br_a, br_b;
  assign br_a = ((BR_FWD != 0) && mem_reg_write && !mem_mem_read && (mem_dest == rs) && (rs != '0))
                ? mem_fwd_data : rd1;
  assign br_b = ((BR_FWD != 0) && mem_reg_write && !mem_mem_read && (mem_dest == rt) && (rt != '0))
                ? mem_fwd_data : rd2;

  logic hazard;

  decode_hazard_unit #(
    .AW     (AW),
    .BR_FWD (BR_FWD)
  ) u_hazard (
    .if_valid      (if_valid),
    .rs            (rs),
    .rt            (rt),
    .rt_src        (rt_src),
    .br_rs         (is_beq || is_bne || is_jr),
    .br_rt         (is_beq || is_bne),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_dest       (ex_dest),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_dest      (mem_dest),
    .ex_stall      (ex_stall),
    .hazard        (hazard),
    .id_stall      (id_stall)
  );

  logic br_eq, br_taken;
  assign br_eq    = (br_a == br_b);
  assign br_taken = (is_beq && br_eq) || (is_bne && !br_eq);

  assign id_redirect = if_valid && !id_stall && (br_taken || is_j || is_jal || is_jr);

  always_comb begin
    if (is_jr)              id_redirect_pc = br_a[PC_W-1:0];
    else if (is_j || is_jal) id_redirect_pc = if_instr[PC_W-1:0];
    else                    id_redirect_pc = if_pc_plus1 + imm_ext[PC_W-1:0];
  end

  // ID/EX register: hold on ex_stall, bubble on hazard or empty slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_valid  <= 1'b0;
      idex_ctrl   <= '0;
      idex_rs     <= '0;
      idex_rt     <= '0;
      idex_dest   <= '0;
      idex_rdata1 <= '0;
      idex_rdata2 <= '0;
      idex_imm    <= '0;
      idex_shamt  <= '0;
      idex_link   <= '0;
    end else if (!ex_stall) begin
      if (hazard || !if_valid) begin
        idex_valid  <= 1'b0;
        idex_ctrl   <= '0;
        idex_rs     <= '0;
        idex_rt     <= '0;
        idex_dest   <= '0;
        idex_rdata1 <= '0;
        idex_rdata2 <= '0;
        idex_imm    <= '0;
        idex_shamt  <= '0;
        idex_link   <= '0;
      end else begin
        idex_valid  <= 1'b1;
        idex_ctrl   <= ctrl;
        idex_rs     <= rs;
        idex_rt     <= rt;
        idex_dest   <= dest;
        idex_rdata1 <= rd1;
        idex_rdata2 <= rd2;
        idex_imm    <= imm_ext;
        idex_shamt  <= shamt;
        idex_link   <= if_pc_plus1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: scoreboarded ID/EX slot plus inline stall/redirect checks.
// Latency: expected ID/EX contents are queued before each edge and compared just after it.
// Backpressure: ex_stall hold and hazard bubbles are exercised directly.
module tb_decode_stage_pipe;
  import core_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [9:0]  link;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [9:0]  if_pc_plus1;
  logic        ex_stall, ex_reg_write, ex_mem_read;
  logic [4:0]  ex_dest;
  logic        mem_reg_write, mem_mem_read;
  logic [4:0]  mem_dest;
  logic [31:0] mem_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;

  logic        id_stall, id_redirect, idex_valid;
  logic [9:0]  id_redirect_pc, idex_ctrl, idex_link;
  logic [4:0]  idex_rs, idex_rt, idex_dest, idex_shamt;
  logic [31:0] idex_rdata1, idex_rdata2, idex_imm;

  logic        nf_id_stall, nf_id_redirect, nf_idex_valid;
  logic [9:0]  nf_id_redirect_pc, nf_idex_ctrl, nf_idex_link;
  logic [4:0]  nf_idex_rs, nf_idex_rt, nf_idex_dest, nf_idex_shamt;
  logic [31:0] nf_idex_rdata1, nf_idex_rdata2, nf_idex_imm;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t mon_e, mon_g;
  localparam exp_t BUB = '0;

  always #5 clk = ~clk;

  decode_stage_pipe #(.BR_FWD(1)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus1(if_pc_plus1),
    .ex_stall(ex_stall), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
    .mem_fwd_data(mem_fwd_data), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_stall(id_stall), .id_redirect(id_redirect), .id_redirect_pc(id_redirect_pc),
    .idex_valid(idex_valid), .idex_ctrl(idex_ctrl), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_dest(idex_dest), .idex_rdata1(idex_rdata1), .idex_rdata2(idex_rdata2),
    .idex_imm(idex_imm), .idex_shamt(idex_shamt), .idex_link(idex_link)
  );

  decode_stage_pipe #(.BR_FWD(0)) dut_nf (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus1(if_pc_plus1),
    .ex_stall(ex_stall), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_dest(mem_dest),
    .mem_fwd_data(mem_fwd_data), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
    .id_stall(nf_id_stall), .id_redirect(nf_id_redirect), .id_redirect_pc(nf_id_redirect_pc),
    .idex_valid(nf_idex_valid), .idex_ctrl(nf_idex_ctrl), .idex_rs(nf_idex_rs), .idex_rt(nf_idex_rt),
    .idex_dest(nf_idex_dest), .idex_rdata1(nf_idex_rdata1), .idex_rdata2(nf_idex_rdata2),
    .idex_imm(nf_idex_imm), .idex_shamt(nf_idex_shamt), .idex_link(nf_idex_link)
  );

  // Scoreboard consumer: one expected ID/EX slot per queued edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_g = {idex_valid, idex_ctrl, idex_rs, idex_rt, idex_dest, idex_rdata1, idex_rdata2,
               idex_imm, idex_shamt, idex_link};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL idex_slot @%0t: got v=%0b ctrl=%h rs=%0d rt=%0d dest=%0d rd1=%h rd2=%h imm=%h sh=%0d link=%h; want v=%0b ctrl=%h rs=%0d rt=%0d dest=%0d rd1=%h rd2=%h imm=%h sh=%0d link=%h",
                 $time, mon_g.valid, mon_g.ctrl, mon_g.rs, mon_g.rt, mon_g.dest, mon_g.rd1, mon_g.rd2,
                 mon_g.imm, mon_g.shamt, mon_g.link, mon_e.valid, mon_e.ctrl, mon_e.rs, mon_e.rt,
                 mon_e.dest, mon_e.rd1, mon_e.rd2, mon_e.imm, mon_e.shamt, mon_e.link);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input int s, input int t, input int d, input int sh, input logic [5:0] fn);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int s, input int t, input logic [15:0] im);
    return {op, 5'(s), 5'(t), im};
  endfunction

  function automatic logic [9:0] mkctrl(input logic rw, input logic mr, input logic mw, input logic m2r,
                                        input logic src, input logic jl, input alu_op_e op);
    return {rw, mr, mw, m2r, src, jl, 4'(op)};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] w, input logic [9:0] c, input logic [4:0] d,
                                  input logic [31:0] r1, input logic [31:0] r2, input logic [9:0] lk,
                                  input logic zx);
    exp_t e;
    e.valid = 1'b1;
    e.ctrl  = c;
    e.rs    = w[25:21];
    e.rt    = w[20:16];
    e.dest  = d;
    e.rd1   = r1;
    e.rd2   = r2;
    e.imm   = zx ? {16'h0000, w[15:0]} : {{16{w[15]}}, w[15:0]};
    e.shamt = w[10:6];
    e.link  = lk;
    return e;
  endfunction

  task automatic idle_inputs();
    if_valid = 0; if_instr = 0; if_pc_plus1 = 0; ex_stall = 0; ex_reg_write = 0; ex_mem_read = 0;
    ex_dest = 0; mem_reg_write = 0; mem_mem_read = 0; mem_dest = 0; mem_fwd_data = 0;
    wb_we = 0; wb_dest = 0; wb_data = 0;
  endtask

  task automatic cycle(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst = 0;
    idle_inputs();
    #1;
    checks++; if (idex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", idex_valid); end
    checks++; if (id_stall !== 1'b0 || id_redirect !== 1'b0) begin errors++; $display("FAIL reset_comb: got stall=%0b redir=%0b want 0/0", id_stall, id_redirect); end
    @(posedge clk); #2;
    rst = 1;
    wb_we = 1; wb_dest = 7; wb_data = 32'h0000_1234;
    cycle(BUB);
    wb_we = 0;
    w = enc_r(7, 0, 1, 0, FN_OR);
    if_valid = 1; if_instr = w; if_pc_plus1 = 10'h010;
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,0,ALU_OR), 5'd1, 32'h0000_1234, 32'h0, 10'h010, 1'b0));
    rst = 0;
    #1;
    checks++; if (idex_valid !== 1'b0 || idex_ctrl !== 10'h0 || idex_dest !== 5'd0) begin errors++; $display("FAIL midrun_reset_ctrl: got v=%0b ctrl=%h dest=%0d want 0", idex_valid, idex_ctrl, idex_dest); end
    checks++; if (idex_rdata1 !== 32'h0 || idex_link !== 10'h0 || idex_imm !== 32'h0) begin errors++; $display("FAIL midrun_reset_data: got rd1=%h link=%h imm=%h want 0", idex_rdata1, idex_link, idex_imm); end
    #1;
    rst = 1;
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,0,ALU_OR), 5'd1, 32'h0, 32'h0, 10'h010, 1'b0));
  endtask

  task automatic test_load_use();
    logic [31:0] w;
    idle_inputs();
    w = enc_r(2, 4, 3, 0, FN_ADD);
    if_valid = 1; if_instr = w; if_pc_plus1 = 10'h020;
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 2;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall: got %0b want 1", id_stall); end
    checks++; if (id_redirect !== 1'b0) begin errors++; $display("FAIL loaduse_redirect: got %0b want 0", id_redirect); end
    cycle(BUB);
    ex_mem_read = 0; ex_reg_write = 0;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL loaduse_release: got %0b want 0", id_stall); end
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,0,ALU_ADD), 5'd3, 32'h0, 32'h0, 10'h020, 1'b0));
    // rt of addi is a destination, not a source
    w = enc_i(OP_ADDI, 6, 2, 16'h0001);
    if_instr = w; ex_mem_read = 1; ex_reg_write = 1; ex_dest = 2;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL loaduse_rt_not_src: got %0b want 0", id_stall); end
    cycle(mk_exp(w, mkctrl(1,0,0,0,1,0,ALU_ADD), 5'd2, 32'h0, 32'h0, 10'h020, 1'b0));
  endtask

  task automatic test_branch();
    logic [31:0] w;
    idle_inputs();
    wb_we = 1; wb_dest = 5; wb_data = 32'd7;
    cycle(BUB);
    wb_we = 0;
    w = enc_i(OP_BEQ, 1, 5, 16'h0003);
    if_valid = 1; if_instr = w; if_pc_plus1 = 10'h3FE;
    mem_reg_write = 1; mem_dest = 1; mem_fwd_data = 32'd7;
    #1;
    checks++; if (id_stall !== 1'b0 || id_redirect !== 1'b1) begin errors++; $display("FAIL beq_fwd_taken: got stall=%0b redir=%0b want 0/1", id_stall, id_redirect); end
    checks++; if (id_redirect_pc !== 10'h001) begin errors++; $display("FAIL beq_wrap_pc: got %h want 001", id_redirect_pc); end
    checks++; if (nf_id_stall !== 1'b1 || nf_id_redirect !== 1'b0) begin errors++; $display("FAIL beq_nofwd_stall: got stall=%0b redir=%0b want 1/0", nf_id_stall, nf_id_redirect); end
    cycle(mk_exp(w, 10'h0, 5'd5, 32'h0, 32'd7, 10'h3FE, 1'b0));
    checks++; if (nf_idex_valid !== 1'b0) begin errors++; $display("FAIL beq_nofwd_bubble: got %0b want 0", nf_idex_valid); end
    mem_fwd_data = 32'd8;
    #1;
    checks++; if (id_redirect !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %0b want 0", id_redirect); end
    cycle(mk_exp(w, 10'h0, 5'd5, 32'h0, 32'd7, 10'h3FE, 1'b0));
    w = enc_i(OP_BNE, 1, 5, 16'hFFFE);
    if_instr = w; if_pc_plus1 = 10'h001;
    #1;
    checks++; if (id_redirect !== 1'b1 || id_redirect_pc !== 10'h3FF) begin errors++; $display("FAIL bne_back_wrap: got redir=%0b pc=%h want 1/3ff", id_redirect, id_redirect_pc); end
    cycle(mk_exp(w, 10'h0, 5'd5, 32'h0, 32'd7, 10'h001, 1'b0));
    ex_reg_write = 1; ex_dest = 5;
    #1;
    checks++; if (id_stall !== 1'b1 || id_redirect !== 1'b0) begin errors++; $display("FAIL branch_ex_hazard: got stall=%0b redir=%0b want 1/0", id_stall, id_redirect); end
    cycle(BUB);
    ex_reg_write = 0; mem_mem_read = 1;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL branch_mem_load: got %0b want 1", id_stall); end
    cycle(BUB);
  endtask

  task automatic test_wb_bypass();
    logic [31:0] w;
    idle_inputs();
    wb_we = 1; wb_dest = 9; wb_data = 32'hDEAD_BEEF;
    w = enc_r(9, 0, 1, 0, FN_OR);
    if_valid = 1; if_instr = w; if_pc_plus1 = 10'h040;
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,0,ALU_OR), 5'd1, 32'hDEAD_BEEF, 32'h0, 10'h040, 1'b0));
    wb_dest = 0; wb_data = 32'h0000_0055;
    w = enc_r(0, 0, 1, 0, FN_OR);
    if_instr = w;
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,0,ALU_OR), 5'd1, 32'h0, 32'h0, 10'h040, 1'b0));
    wb_we = 0;
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,0,ALU_OR), 5'd1, 32'h0, 32'h0, 10'h040, 1'b0));
  endtask

  task automatic test_jal();
    logic [31:0] w;
    idle_inputs();
    w = {OP_JAL, 26'h155};
    if_valid = 1; if_instr = w; if_pc_plus1 = 10'h020;
    #1;
    checks++; if (id_redirect !== 1'b1 || id_redirect_pc !== 10'h155) begin errors++; $display("FAIL jal_redirect: got redir=%0b pc=%h want 1/155", id_redirect, id_redirect_pc); end
    cycle(mk_exp(w, mkctrl(1,0,0,0,0,1,ALU_NOP), 5'd31, 32'h0, 32'h0, 10'h020, 1'b0));
    w = enc_r(9, 0, 0, 0, FN_JR);
    if_instr = w; if_pc_plus1 = 10'h050;
    #1;
    checks++; if (id_redirect !== 1'b1 || id_redirect_pc !== 10'h2EF) begin errors++; $display("FAIL jr_redirect: got redir=%0b pc=%h want 1/2ef", id_redirect, id_redirect_pc); end
    cycle(mk_exp(w, 10'h0, 5'd0, 32'hDEAD_BEEF, 32'h0, 10'h050, 1'b0));
  endtask

  task automatic test_ex_stall();
    logic [31:0] w;
    exp_t e_sw;
    idle_inputs();
    w = enc_i(OP_SW, 5, 9, 16'h0004);
    if_valid = 1; if_instr = w; if_pc_plus1 = 10'h060;
    e_sw = mk_exp(w, mkctrl(0,0,1,0,1,0,ALU_ADD), 5'd9, 32'd7, 32'hDEAD_BEEF, 10'h060, 1'b0);
    cycle(e_sw);
    w = enc_i(OP_BEQ, 0, 0, 16'h0002);
    if_instr = w; if_pc_plus1 = 10'h070; ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_stall !== 1'b1 || id_redirect !== 1'b0) begin errors++; $display("FAIL exstall_hold_%0d: got stall=%0b redir=%0b want 1/0", i, id_stall, id_redirect); end
      cycle(e_sw);
    end
    ex_stall = 0;
    #1;
    checks++; if (id_redirect !== 1'b1 || id_redirect_pc !== 10'h072) begin errors++; $display("FAIL exstall_release_beq: got redir=%0b pc=%h want 1/072", id_redirect, id_redirect_pc); end
    cycle(mk_exp(w, 10'h0, 5'd0, 32'h0, 32'h0, 10'h070, 1'b0));
    w = enc_i(OP_ORI, 0, 2, 16'h8000);
    if_instr = w; if_pc_plus1 = 10'h080;
    cycle(mk_exp(w, mkctrl(1,0,0,0,1,0,ALU_OR), 5'd2, 32'h0, 32'h0, 10'h080, 1'b1));
    w = enc_i(OP_ADDI, 0, 2, 16'h8000);
    if_instr = w;
    cycle(mk_exp(w, mkctrl(1,0,0,0,1,0,ALU_ADD), 5'd2, 32'h0, 32'h0, 10'h080, 1'b0));
    w = enc_i(OP_LW, 5, 3, 16'h0010);
    if_instr = w;
    cycle(mk_exp(w, mkctrl(1,1,0,1,1,0,ALU_ADD), 5'd3, 32'd7, 32'h0, 10'h080, 1'b0));
    w = enc_i(6'h3F, 1, 2, 16'h0005);
    if_instr = w;
    cycle(mk_exp(w, 10'h0, 5'd2, 32'h0, 32'h0, 10'h080, 1'b0));
    if_valid = 0;
    cycle(BUB);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_wb_bypass();
    test_jal();
    test_ex_stall();
    @(posedge clk); #2;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised decode stage for the 5-stage MIPS-subset core, the successor to the combinational decode block. It decodes the IF/ID instruction, reads the internal register file with WB write-through bypass, and resolves branches and jumps in ID using MEM-stage forwarding. It detects load-use and branch-operand hazards, generates stall and redirect, and owns the ID/EX pipeline register with bubble insertion and downstream hold.

Parameters:
DATA_W, 32, datapath and register width
PC_W, 10, instruction-address width (word addressed)
NREGS, 32, register count; AW = clog2(NREGS), rs/rt/rd fields truncated to AW
BR_FWD, 1, 1 = forward MEM-stage ALU result into branch/jr compare; 0 = stall instead

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
if_valid  in  1  IF/ID slot holds a live instruction
if_instr  in  32  instruction
if_pc_plus1  in  PC_W  PC+1 of instruction
ex_stall  in  1  downstream hold; ID/EX must not advance
ex_reg_write, ex_mem_read  in  1 each  EX-stage instruction control
ex_dest  in  AW  EX-stage destination
mem_reg_write, mem_mem_read  in  1 each  MEM-stage control
mem_dest  in  AW  MEM-stage destination
mem_fwd_data  in  DATA_W  MEM-stage ALU result
wb_we  in  1  WB write enable
wb_dest  in  AW  WB destination (already 31 for jal)
wb_data  in  DATA_W  WB write data
id_stall  out  1  hold PC and IF/ID
id_redirect  out  1  taken branch/jump; IF squashes its slot
id_redirect_pc  out  PC_W  redirect target
idex_valid  out  1  ID/EX slot live
idex_ctrl  out  10  {RegWriteEn,MemReadEn,MemWriteEn,MemtoReg,ALUSrc,jal,ALUOp[3:0]}
idex_rs, idex_rt, idex_dest  out  AW each  register indices for EX forwarding/WB
idex_rdata1, idex_rdata2  out  DATA_W each  operands (WB-bypassed)
idex_imm  out  DATA_W  extended immediate
idex_shamt  out  5  shift amount
idex_link  out  PC_W  pc_plus1 for jal link

Behaviour:
- Reset (rst=0, async): all idex_* = 0, idex_valid = 0, all registers = 0. id_stall and id_redirect are combinational and evaluate to 0 with idex cleared.
- Register file: write at posedge when wb_we && wb_dest!=0. Reg 0 reads 0. Combinational read returns wb_data when wb_we && wb_dest==src && src!=0 (write-through).
- Branch operand select per source, in priority: MEM fwd (BR_FWD && mem_reg_write && !mem_mem_read && mem_dest==src!=0), then WB bypass, then RF.
- Decode: RegDst ? rd : rt; jal forces dest 31. Immediate is zero-extended for andi/ori (0x0C/0x0D) and sign-extended otherwise. Unknown opcode decodes as nop (ctrl 0).
- Hazards (h = if_valid && rule):
  - load-use: ex_mem_read && ex_dest!=0 && (ex_dest==rs || (ex_dest==rt && rt is a source)).
  - branch/jr source matches a nonzero ex_dest with ex_reg_write.
  - branch/jr source matches a nonzero mem_dest with mem_mem_read, or with mem_reg_write when BR_FWD=0.
  - id_stall = h || ex_stall.
- Redirect: id_redirect = if_valid && !id_stall && (taken beq/bne || j || jal || jr).
  - beq/bne target = if_pc_plus1 + imm[PC_W-1:0], modulo 2^PC_W (wraps).
  - j/jal target = instr[PC_W-1:0].
  - jr target = rs operand[PC_W-1:0].
- ID/EX update at posedge:
  - ex_stall: hold all fields.
  - else h or !if_valid: bubble (valid 0, ctrl 0, other fields don't-care but zeroed).
  - else load the decoded instruction, valid 1. Branches/j enter with ctrl 0 and valid 1; jal enters with RegWriteEn=1, dest 31.
- A simultaneous WB write and read of the same register returns the new data in the same cycle.
- A mid-operation reset discards the ID/EX contents immediately.

Decomposition:
- Package core_pkg holds:
  - opcode/funct constants: R 0x00, j 0x02, jal 0x03, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B, jr funct 0x08.
  - ALUOp encodings and idex_ctrl bit indices.
- Sub-module decode_hazard_unit: pure combinational hazard and stall logic. Register file and control decode stay inline.

Test Plan:
1. Reset low mid-run with idex_valid=1 -> all idex_* are 0 asynchronously. After release, reading any register gives 0.
2. lw r2 in EX (ex_mem_read=1, ex_dest=2), decode `add r3,r2,r4` -> id_stall=1 and the bubble enters (idex_valid=0). Next cycle with ex_mem_read=0 -> add loads and idex_rs=2.
3. `beq r1,r5,+3` at pc_plus1=0x3FE, with r1 from mem_fwd_data=7 and RF r5=7 -> id_redirect=1, id_redirect_pc=0x001 (wrap). With BR_FWD=0 the same setup stalls one cycle instead.
4. wb_we=1, wb_dest=9, wb_data=0xDEADBEEF while decoding `or r1,r9,r0` -> idex_rdata1=0xDEADBEEF on the same edge. Writing to dest 0 leaves r0 reading 0.
5. `jal 0x155` with pc_plus1=0x020 -> redirect 0x155; ID/EX gets dest 31, idex_link=0x020, RegWriteEn=1.
6. ex_stall=1 for 3 cycles holding a valid sw -> ID/EX unchanged, id_stall=1, and id_redirect=0 even if a taken beq sits in IF/ID. `ori` with imm 0x8000 -> idex_imm=0x00008000.
